// File: rtl/caracter_a_hz.sv
// caracter_a_hz
// Turns a stream of keypad codes into a committed frequency in Hz.
// The user types decimal digits. ENTER validates the entry against
// [FREQ_MIN, FREQ_MAX]. BORRAR discards the entry. RETROCESO removes
// the last digit.
//
// Ports
//   clk          : rising-edge clock for all state
//   reset        : synchronous, active-high reset
//   digito_valid : a key code is present on digito
//   digito       : key code (0-9 digit, 10 ENTER, 11 BORRAR, 12 RETROCESO,
//                  13-15 ignored)
//   digito_ready : a key is accepted this cycle (low only while validating)
//   freq_Hz      : committed frequency
//   freq_valid   : one-cycle pulse when freq_Hz is updated
//   error        : one-cycle pulse when an entry is rejected
//   freq_edicion : value of the entry in progress
//   n_digitos    : number of digits typed in the entry in progress
//   editando     : high while an entry is being edited
module caracter_a_hz #(
  parameter int FREQ_MIN    = 1,
  parameter int FREQ_MAX    = 10000,
  parameter int FREQ_RESET  = 1000,
  parameter int MAX_DIGITOS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        digito_valid,
  input  logic [3:0]  digito,
  output logic        digito_ready,
  output logic [13:0] freq_Hz,
  output logic        freq_valid,
  output logic        error,
  output logic [16:0] freq_edicion,
  output logic [2:0]  n_digitos,
  output logic        editando
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EDITANDO = 2'd1,
    VALIDAR  = 2'd2
  } state_t;

  localparam logic [3:0]  KEY_ENTER     = 4'd10;
  localparam logic [3:0]  KEY_BORRAR    = 4'd11;
  localparam logic [3:0]  KEY_RETROCESO = 4'd12;
  localparam logic [16:0] F_MIN         = 17'(FREQ_MIN);
  localparam logic [16:0] F_MAX         = 17'(FREQ_MAX);
  localparam logic [13:0] F_RESET       = 14'(FREQ_RESET);
  localparam logic [2:0]  N_MAX         = 3'(MAX_DIGITOS);

  state_t      state_q, state_d;
  logic [16:0] freq_edicion_q, freq_edicion_d;
  logic [2:0]  n_digitos_q, n_digitos_d;
  logic [13:0] freq_hz_q, freq_hz_d;
  logic        freq_valid_q, freq_valid_d;
  logic        error_q, error_d;
  logic        editando_q, editando_d;

  logic        key_accepted;
  logic        key_is_digit;
  logic [16:0] edicion_x10;
  logic        in_range;

  // Keys are only taken while not validating, so the VALIDAR cycle is a
  // clean one-cycle window in which the entry cannot change.
  assign digito_ready = (state_q != VALIDAR);
  assign key_accepted = digito_valid && digito_ready;
  assign key_is_digit = (digito <= 4'd9);

  // x*10 as (x<<3)+(x<<1); at most 5 digits, so this never overflows 17 bits.
  assign edicion_x10 = (freq_edicion_q << 3) + (freq_edicion_q << 1);
  assign in_range    = (freq_edicion_q >= F_MIN) && (freq_edicion_q <= F_MAX);

  // Next-state and datapath: every target has a default so pulses fall back
  // to zero and held values stay put unless a key or validation changes them.
  always_comb begin
    state_d        = state_q;
    freq_edicion_d = freq_edicion_q;
    n_digitos_d    = n_digitos_q;
    freq_hz_d      = freq_hz_q;
    freq_valid_d   = 1'b0;
    error_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key_accepted && key_is_digit) begin
          freq_edicion_d = {13'd0, digito};
          n_digitos_d    = 3'd1;
          state_d        = EDITANDO;
        end
      end

      EDITANDO: begin
        if (key_accepted) begin
          if (key_is_digit) begin
            // Digits past the limit are dropped silently.
            if (n_digitos_q < N_MAX) begin
              freq_edicion_d = edicion_x10 + {13'd0, digito};
              n_digitos_d    = n_digitos_q + 3'd1;
            end
          end else if (digito == KEY_ENTER) begin
            state_d = VALIDAR;
          end else if (digito == KEY_BORRAR) begin
            freq_edicion_d = '0;
            n_digitos_d    = '0;
            state_d        = IDLE;
          end else if (digito == KEY_RETROCESO) begin
            freq_edicion_d = freq_edicion_q / 17'd10;
            n_digitos_d    = n_digitos_q - 3'd1;
            if (n_digitos_q == 3'd1) begin
              freq_edicion_d = '0;
              state_d        = IDLE;
            end
          end
        end
      end

      VALIDAR: begin
        if (in_range) begin
          freq_hz_d    = freq_edicion_q[13:0];
          freq_valid_d = 1'b1;
        end else begin
          error_d = 1'b1;
        end
        freq_edicion_d = '0;
        n_digitos_d    = '0;
        state_d        = IDLE;
      end

      default: begin
        state_d        = IDLE;
        freq_edicion_d = '0;
        n_digitos_d    = '0;
      end
    endcase

    editando_d = (state_d == EDITANDO);
  end

  // State register. Reset wins over any key on the same edge and drops any
  // pending pulse, so an aborted entry leaves no trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      freq_edicion_q <= '0;
      n_digitos_q    <= '0;
      freq_hz_q      <= F_RESET;
      freq_valid_q   <= 1'b0;
      error_q        <= 1'b0;
      editando_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      freq_edicion_q <= freq_edicion_d;
      n_digitos_q    <= n_digitos_d;
      freq_hz_q      <= freq_hz_d;
      freq_valid_q   <= freq_valid_d;
      error_q        <= error_d;
      editando_q     <= editando_d;
    end
  end

  assign freq_Hz      = freq_hz_q;
  assign freq_valid   = freq_valid_q;
  assign error        = error_q;
  assign freq_edicion = freq_edicion_q;
  assign n_digitos    = n_digitos_q;
  assign editando     = editando_q;

endmodule

// File: tb/tb_caracter_a_hz.sv
// tb_caracter_a_hz
// Directed-vector bench for caracter_a_hz. Each table record gives one
// cycle of inputs and the outputs expected just after that clock edge.
// A few hand-written sequences follow, for the multi-cycle corner cases.
module tb_caracter_a_hz;

  logic        clk;
  logic        reset;
  logic        digito_valid;
  logic [3:0]  digito;
  logic        digito_ready;
  logic [13:0] freq_Hz;
  logic        freq_valid;
  logic        error;
  logic [16:0] freq_edicion;
  logic [2:0]  n_digitos;
  logic        editando;

  int n_vectors     = 0;
  int n_miscompares = 0;

  caracter_a_hz dut (
    .clk          (clk),
    .reset        (reset),
    .digito_valid (digito_valid),
    .digito       (digito),
    .digito_ready (digito_ready),
    .freq_Hz      (freq_Hz),
    .freq_valid   (freq_valid),
    .error        (error),
    .freq_edicion (freq_edicion),
    .n_digitos    (n_digitos),
    .editando     (editando)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [3:0]  dig;
    logic        rdy;
    logic [13:0] freq;
    logic        fv;
    logic        err;
    logic [16:0] ed;
    logic [2:0]  n;
    logic        edt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input int rst, input int vld, input int dig,
                             input int rdy, input int freq, input int fv,
                             input int err, input int ed, input int n,
                             input int edt);
    vec_t r;
    r.rst  = 1'(rst);
    r.vld  = 1'(vld);
    r.dig  = 4'(dig);
    r.rdy  = 1'(rdy);
    r.freq = 14'(freq);
    r.fv   = 1'(fv);
    r.err  = 1'(err);
    r.ed   = 17'(ed);
    r.n    = 3'(n);
    r.edt  = 1'(edt);
    return r;
  endfunction

  // Drive inputs on the falling edge, then let one rising edge pass and
  // sample 1 ns later.
  task automatic applyStimulus(input logic rst, input logic vld, input logic [3:0] dig);
    @(negedge clk);
    reset        = rst;
    digito_valid = vld;
    digito       = dig;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [37:0] actual,
                             input logic [37:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [37:0] pack_outputs();
    return {digito_ready, freq_Hz, freq_valid, error, freq_edicion, n_digitos, editando};
  endfunction

  initial begin
    reset        = 1'b1;
    digito_valid = 1'b0;
    digito       = 4'd0;

    // fields: rst vld dig | rdy freq fv err ed n edt
    // reset state
    vecs.push_back(v(1,0,0,   1,1000,0,0,0,0,0));
    // commit 2500
    vecs.push_back(v(0,1,2,   1,1000,0,0,2,1,1));
    vecs.push_back(v(0,1,5,   1,1000,0,0,25,2,1));
    vecs.push_back(v(0,1,0,   1,1000,0,0,250,3,1));
    vecs.push_back(v(0,1,0,   1,1000,0,0,2500,4,1));
    vecs.push_back(v(0,1,10,  0,1000,0,0,2500,4,0));
    vecs.push_back(v(0,0,0,   1,2500,1,0,0,0,0));
    vecs.push_back(v(0,0,0,   1,2500,0,0,0,0,0));
    // upper bound accepted
    vecs.push_back(v(0,1,1,   1,2500,0,0,1,1,1));
    vecs.push_back(v(0,1,0,   1,2500,0,0,10,2,1));
    vecs.push_back(v(0,1,0,   1,2500,0,0,100,3,1));
    vecs.push_back(v(0,1,0,   1,2500,0,0,1000,4,1));
    vecs.push_back(v(0,1,0,   1,2500,0,0,10000,5,1));
    vecs.push_back(v(0,1,10,  0,2500,0,0,10000,5,0));
    vecs.push_back(v(0,0,0,   1,10000,1,0,0,0,0));
    // one above upper bound rejected
    vecs.push_back(v(0,1,1,   1,10000,0,0,1,1,1));
    vecs.push_back(v(0,1,0,   1,10000,0,0,10,2,1));
    vecs.push_back(v(0,1,0,   1,10000,0,0,100,3,1));
    vecs.push_back(v(0,1,0,   1,10000,0,0,1000,4,1));
    vecs.push_back(v(0,1,1,   1,10000,0,0,10001,5,1));
    vecs.push_back(v(0,1,10,  0,10000,0,0,10001,5,0));
    vecs.push_back(v(0,0,0,   1,10000,0,1,0,0,0));
    vecs.push_back(v(0,0,0,   1,10000,0,0,0,0,0));
    // lower bound: 0 rejected, reset value kept
    vecs.push_back(v(1,0,0,   1,1000,0,0,0,0,0));
    vecs.push_back(v(0,1,0,   1,1000,0,0,0,1,1));
    vecs.push_back(v(0,1,10,  0,1000,0,0,0,1,0));
    vecs.push_back(v(0,0,0,   1,1000,0,1,0,0,0));
    // keys ignored in IDLE
    vecs.push_back(v(0,1,13,  1,1000,0,0,0,0,0));
    vecs.push_back(v(0,1,12,  1,1000,0,0,0,0,0));
    vecs.push_back(v(0,1,11,  1,1000,0,0,0,0,0));
    vecs.push_back(v(0,1,10,  1,1000,0,0,0,0,0));
    // digit limit and backspace
    vecs.push_back(v(0,1,9,   1,1000,0,0,9,1,1));
    vecs.push_back(v(0,1,9,   1,1000,0,0,99,2,1));
    vecs.push_back(v(0,1,9,   1,1000,0,0,999,3,1));
    vecs.push_back(v(0,1,9,   1,1000,0,0,9999,4,1));
    vecs.push_back(v(0,1,9,   1,1000,0,0,99999,5,1));
    vecs.push_back(v(0,1,9,   1,1000,0,0,99999,5,1));
    vecs.push_back(v(0,1,12,  1,1000,0,0,9999,4,1));
    vecs.push_back(v(0,1,12,  1,1000,0,0,999,3,1));
    vecs.push_back(v(0,1,12,  1,1000,0,0,99,2,1));
    vecs.push_back(v(0,1,12,  1,1000,0,0,9,1,1));
    vecs.push_back(v(0,1,12,  1,1000,0,0,0,0,0));
    // leading zero, dropped keys while editing, then clear
    vecs.push_back(v(0,1,0,   1,1000,0,0,0,1,1));
    vecs.push_back(v(0,1,5,   1,1000,0,0,5,2,1));
    vecs.push_back(v(0,0,7,   1,1000,0,0,5,2,1));
    vecs.push_back(v(0,1,14,  1,1000,0,0,5,2,1));
    vecs.push_back(v(0,1,11,  1,1000,0,0,0,0,0));
    // clear then ENTER in IDLE gives no pulse
    vecs.push_back(v(0,1,7,   1,1000,0,0,7,1,1));
    vecs.push_back(v(0,1,11,  1,1000,0,0,0,0,0));
    vecs.push_back(v(0,1,10,  1,1000,0,0,0,0,0));
    // digit during VALIDAR is dropped
    vecs.push_back(v(0,1,3,   1,1000,0,0,3,1,1));
    vecs.push_back(v(0,1,10,  0,1000,0,0,3,1,0));
    vecs.push_back(v(0,1,5,   1,3,1,0,0,0,0));
    vecs.push_back(v(0,0,0,   1,3,0,0,0,0,0));
    // reset together with ENTER mid-entry
    vecs.push_back(v(0,1,4,   1,3,0,0,4,1,1));
    vecs.push_back(v(0,1,2,   1,3,0,0,42,2,1));
    vecs.push_back(v(1,1,10,  1,1000,0,0,0,0,0));
    vecs.push_back(v(0,0,0,   1,1000,0,0,0,0,0));
    // reset during VALIDAR aborts without a pulse
    vecs.push_back(v(0,1,8,   1,1000,0,0,8,1,1));
    vecs.push_back(v(0,1,10,  0,1000,0,0,8,1,0));
    vecs.push_back(v(1,0,0,   1,1000,0,0,0,0,0));
    vecs.push_back(v(0,0,0,   1,1000,0,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].dig);
      checkOutput($sformatf("vec%0d", i), pack_outputs(),
                  {vecs[i].rdy, vecs[i].freq, vecs[i].fv, vecs[i].err,
                   vecs[i].ed, vecs[i].n, vecs[i].edt});
    end

    // Hand sequence: hold a digit on the bus through VALIDAR. Check that
    // ready is low mid-cycle, that the pulse lasts one cycle, and that the
    // held digit only starts a new entry once the FSM is back in IDLE.
    applyStimulus(1'b0, 1'b1, 4'd6);
    applyStimulus(1'b0, 1'b1, 4'd10);
    @(negedge clk);
    digito_valid = 1'b1;
    digito       = 4'd6;
    checkOutput("ready_low_in_validar", {37'd0, digito_ready}, 38'd0);
    @(posedge clk);
    #1;
    checkOutput("commit_6", {23'd0, freq_Hz, freq_valid}, {23'd0, 14'd6, 1'b1});
    checkOutput("edicion_cleared", {18'd0, freq_edicion, n_digitos}, 38'd0);
    @(posedge clk);
    #1;
    checkOutput("pulse_one_cycle", {36'd0, freq_valid, error}, 38'd0);
    checkOutput("held_digit_new_entry", {17'd0, freq_edicion, n_digitos, editando},
                {17'd0, 17'd6, 3'd1, 1'b1});
    applyStimulus(1'b0, 1'b1, 4'd11);
    checkOutput("borrar_after_hold", {17'd0, freq_Hz, n_digitos, editando},
                {17'd0, 14'd6, 3'd0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
